dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-port data RAM between the pipeline's MEM stage (CPU) and a secondary DMA/loader requester. Grants at most one access per cycle, routes 1-cycle-latency read data back to the owning requester, and raises a stall to the pipeline when the CPU is denied. CPU has priority; a starvation counter guarantees DMA forward progress. Sits between the EX/MEM pipeline register outputs and the `Ram` instance.

## Interface
- `ADDR_W`, 10: RAM word-address width. Requesters supply low `ADDR_W` bits.
- `DATA_W`, 32: data width.
- `STARVE_MAX`, 4: consecutive denied DMA cycles before DMA is forced a grant. Legal range 1..15.

- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: synchronous, active-low reset.
- `cpu_req` in 1: CPU access request (MEM stage).
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in `ADDR_W`: CPU address.
- `cpu_wdata` in `DATA_W`: CPU write data.
- `cpu_gnt` out 1: CPU access taken this cycle.
- `cpu_stall` out 1: `cpu_req & ~cpu_gnt`; freezes PC and IF/ID/ID-EX/EX-MEM registers.
- `cpu_rvalid` out 1: CPU read data valid on `cpu_rdata`.
- `cpu_rdata` out `DATA_W`: equal to `ram_q`.
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata` in: same meaning, DMA side.
- `dma_gnt`, `dma_rvalid`, `dma_rdata` out: same meaning, DMA side.
- `ram_address` out `ADDR_W`; `ram_data` out `DATA_W`; `ram_wren` out 1; `ram_q` in `DATA_W`: RAM port, 1-cycle registered read.

## Operation
- Grants are combinational from requests and registered state. At most one of `cpu_gnt`/`dma_gnt` is high.
- FSM `pri_q`, two states:
  - `PRI_CPU`: CPU wins if it requests; otherwise DMA wins if it requests.
  - `PRI_DMA`: DMA wins if it requests; otherwise CPU wins.
- Starvation counter `starve_q` (4 bits):
  - Increments when `dma_req & cpu_gnt`.
  - Clears when `dma_gnt` or `~dma_req`.
  - When the increment would reach `STARVE_MAX`, the next state is `PRI_DMA` and the counter clears.
  - `PRI_DMA` lasts exactly one cycle, then returns to `PRI_CPU` whether or not DMA requested.
- RAM mux: the granted requester drives `ram_address`/`ram_data`. `ram_wren = (cpu_gnt & cpu_we) | (dma_gnt & dma_we)`. With no grant, the CPU fields drive the port and `ram_wren = 0`.
- Read return:
  - A read grant sets `rd_pend_q = 1` and `rd_own_q` to the owner (`OWN_CPU`/`OWN_DMA`).
  - The next cycle, that owner's `*_rvalid` is 1.
  - Otherwise `rd_pend_q` clears.
  - Writes produce no rvalid.
- Requester handshake: a requester holds `req` and its fields stable until it sees `gnt` high. A deasserted request is simply not served; no error.

## Timing
- Grant latency: 0 cycles (same-cycle combinational).
- Read data latency: 1 cycle after grant.
- Back-to-back grants every cycle, with reads and writes interleaved, are allowed.
- Reset (`rst == 0` at an edge) sets:
  - `pri_q = PRI_CPU`, `starve_q = 0`, `rd_pend_q = 0`, `rd_own_q = OWN_CPU`.
  - During reset all `gnt`, `rvalid` and `ram_wren` outputs are forced to 0 and `cpu_stall` is 0.
- Reset mid-read: the pending response is dropped; no rvalid in the cycle after reset releases.
- Simultaneous requests in `PRI_CPU`: CPU granted and `dma_req` counts toward starvation.
- `STARVE_MAX = 1`: every contested cycle alternates CPU, DMA.
- Maximum CPU stall is one cycle per `STARVE_MAX + 1` contested cycles.

## Structure
- Package `dmem_arb_pkg`:
  - `typedef enum logic {OWN_CPU, OWN_DMA} owner_t`
  - `typedef enum logic {PRI_CPU, PRI_DMA} pri_t`
  - counter width constant `STARVE_W = 4`
- One sub-module: `arb_starve_ctr`. It holds the saturating counter and emits a one-cycle `force_dma` pulse. The FSM, grant logic, RAM mux and read-tag registers stay in `dmem_arbiter`.
- Top-level integration:
  - Replaces the direct `Ram` connection.
  - `cpu_stall` feeds the PC enable and the pipeline-register enables.

## Test plan
1. Reset held 2 cycles, then CPU read addr 0x010 only: `cpu_gnt = 1` same cycle, `cpu_rvalid = 1` next cycle with `cpu_rdata` = preloaded 0xDEADBEEF, `dma_rvalid = 0`.
2. DMA write 0x020 ← 0x12345678, then CPU read 0x020 next cycle: `ram_wren = 1` on cycle 0 only; CPU receives 0x12345678 on cycle 2.
3. `STARVE_MAX = 4`, both requesting continuously (CPU reads, DMA reads): CPU granted 4 cycles, DMA on cycle 5, `cpu_stall = 1` on cycle 5 only. The pattern repeats, and rvalid owners match the grant order.
4. CPU read granted, `rst` low on the next edge: no `cpu_rvalid` after reset, `starve_q = 0`, first contested cycle after reset grants CPU.
5. DMA alone, issuing reads every cycle for 8 cycles: `dma_gnt = 1` every cycle, `dma_rvalid` high cycles 1–8, `cpu_stall = 0` throughout.
6. `PRI_DMA` cycle with no `dma_req` and CPU requesting: CPU granted, FSM back to `PRI_CPU` next cycle, counter 0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-RAM arbiter: read-owner tag,
// priority state and starvation counter width.
package dmem_arb_pkg;

  typedef enum logic {OWN_CPU, OWN_DMA} owner_t;
  typedef enum logic {PRI_CPU, PRI_DMA} pri_t;

  localparam int STARVE_W = 4;

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-RAM arbiter (used once for CPU, once for DMA).
// Handshake: the requester holds req/we/addr/wdata stable until it sees gnt
// high in the same cycle; read data returns with rvalid exactly one cycle later.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/dmem_arbiter_starve_ctr.sv
// Counts consecutive cycles in which DMA requested but CPU took the RAM, and
// pulses force_dma when the next increment would hit STARVE_MAX.
module arb_starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_dma_req,
  input  logic                i_cpu_gnt,
  input  logic                i_dma_gnt,
  output logic                o_force_dma,
  output logic [STARVE_W-1:0] o_starve
);

  logic [STARVE_W-1:0] r_cnt;
  logic [STARVE_W-1:0] w_inc;
  logic [STARVE_W-1:0] w_cnt_nxt;

  // Count clears on a DMA grant, an idle DMA, or when it fires the force pulse.
  always_comb begin
    w_inc       = r_cnt + 1'b1;
    w_cnt_nxt   = '0;
    o_force_dma = 1'b0;
    if (i_dma_req && i_cpu_gnt && !i_dma_gnt) begin
      if (w_inc == STARVE_W'(STARVE_MAX)) begin
        o_force_dma = 1'b1;
      end else begin
        w_cnt_nxt = w_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign o_starve = r_cnt;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-RAM arbiter between the MEM stage (CPU, priority) and a
// DMA/loader requester, with starvation-forced DMA slots and read-return routing.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  dmem_arbiter_if.slave       cpu,
  dmem_arbiter_if.slave       dma,
  output logic                cpu_stall,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W-1:0]   ram_data,
  output logic                ram_wren,
  input  logic [DATA_W-1:0]   ram_q,
  output pri_t                o_dbg_pri,
  output logic [STARVE_W-1:0] o_dbg_starve
);

  pri_t                r_pri;
  pri_t                w_pri_nxt;
  logic                r_rd_pend;
  owner_t              r_rd_own;
  logic                w_cpu_gnt;
  logic                w_dma_gnt;
  logic                w_rd_gnt;
  logic                w_force_dma;
  logic [STARVE_W-1:0] w_starve;

  arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk        (clk),
    .rst        (rst),
    .i_dma_req  (dma.req),
    .i_cpu_gnt  (w_cpu_gnt),
    .i_dma_gnt  (w_dma_gnt),
    .o_force_dma(w_force_dma),
    .o_starve   (w_starve)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pri <= PRI_CPU;
    end else begin
      r_pri <= w_pri_nxt;
    end
  end

  // PRI_DMA is a single forced slot; it always falls back to PRI_CPU.
  always_comb begin
    w_pri_nxt = PRI_CPU;
    if (w_force_dma) begin
      w_pri_nxt = PRI_DMA;
    end
  end

  always_comb begin
    w_cpu_gnt = 1'b0;
    w_dma_gnt = 1'b0;
    if (rst) begin
      if (r_pri == PRI_DMA) begin
        w_dma_gnt = dma.req;
        w_cpu_gnt = cpu.req & ~dma.req;
      end else begin
        w_cpu_gnt = cpu.req;
        w_dma_gnt = dma.req & ~cpu.req;
      end
    end
  end

  assign cpu.gnt   = w_cpu_gnt;
  assign dma.gnt   = w_dma_gnt;
  assign cpu_stall = rst & cpu.req & ~w_cpu_gnt;

  // With no grant the CPU fields sit on the port but nothing is written.
  assign ram_address = w_dma_gnt ? dma.addr  : cpu.addr;
  assign ram_data    = w_dma_gnt ? dma.wdata : cpu.wdata;
  assign ram_wren    = (w_cpu_gnt & cpu.we) | (w_dma_gnt & dma.we);
  assign w_rd_gnt    = (w_cpu_gnt & ~cpu.we) | (w_dma_gnt & ~dma.we);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_pend <= 1'b0;
      r_rd_own  <= OWN_CPU;
    end else begin
      r_rd_pend <= w_rd_gnt;
      if (w_rd_gnt) begin
        r_rd_own <= w_dma_gnt ? OWN_DMA : OWN_CPU;
      end
    end
  end

  assign cpu.rvalid = rst & r_rd_pend & (r_rd_own == OWN_CPU);
  assign dma.rvalid = rst & r_rd_pend & (r_rd_own == OWN_DMA);
  assign cpu.rdata  = ram_q;
  assign dma.rdata  = ram_q;

  assign o_dbg_pri    = r_pri;
  assign o_dbg_starve = w_starve;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reset, single reads/writes, CPU/DMA
// contention with starvation slots, reset mid-read, and the idle forced slot.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ram_wren;
  logic [9:0]  ram_address;
  logic [31:0] ram_data;
  logic [31:0] ram_q = '0;
  logic        cpu_stall;
  pri_t        dbg_pri;
  logic [3:0]  dbg_starve;

  logic        ram1_wren;
  logic [9:0]  ram1_address;
  logic [31:0] ram1_data;
  logic [31:0] ram1_q = '0;
  logic        cpu1_stall;
  pri_t        dbg1_pri;
  logic [3:0]  dbg1_starve;

  int n_cmp = 0;
  int n_err = 0;
  int pend  = 0;
  logic [31:0] exp_q[$];
  bit   alt_on = 1'b0;
  int   alt_k  = 0;

  bit [31:0]   mem [0:1023];
  bit [1023:0] wr_seen;

  dmem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) cpu_if ();
  dmem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) dma_if ();
  dmem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) cpu1_if ();
  dmem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) dma1_if ();

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_MAX(4)) u_dut (
    .clk(clk), .rst(rst), .cpu(cpu_if), .dma(dma_if), .cpu_stall(cpu_stall),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q), .o_dbg_pri(dbg_pri), .o_dbg_starve(dbg_starve)
  );

  // Second instance with STARVE_MAX = 1 sees the same request stream.
  assign cpu1_if.req   = cpu_if.req;
  assign cpu1_if.we    = cpu_if.we;
  assign cpu1_if.addr  = cpu_if.addr;
  assign cpu1_if.wdata = cpu_if.wdata;
  assign dma1_if.req   = dma_if.req;
  assign dma1_if.we    = dma_if.we;
  assign dma1_if.addr  = dma_if.addr;
  assign dma1_if.wdata = dma_if.wdata;

  dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_MAX(1)) u_dut1 (
    .clk(clk), .rst(rst), .cpu(cpu1_if), .dma(dma1_if), .cpu_stall(cpu1_stall),
    .ram_address(ram1_address), .ram_data(ram1_data), .ram_wren(ram1_wren),
    .ram_q(ram1_q), .o_dbg_pri(dbg1_pri), .o_dbg_starve(dbg1_starve)
  );

  function automatic logic [31:0] rd_mem(input logic [9:0] a);
    if (wr_seen[a]) return mem[a];
    if (a == 10'h010) return 32'hDEAD_BEEF;
    return 32'hA500_0000 | 32'(a);
  endfunction

  always @(posedge clk) begin
    ram_q <= rd_mem(ram_address);
    if (ram_wren) begin
      mem[ram_address]     <= ram_data;
      wr_seen[ram_address] <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (alt_on) begin
      chk("t3 smax1 cpu_gnt", 32'(cpu1_if.gnt), 32'(alt_k % 2 == 0));
      chk("t3 smax1 dma_gnt", 32'(dma1_if.gnt), 32'(alt_k % 2 == 1));
      alt_k++;
    end
  end

  task automatic drive(input bit cr, input bit cw, input logic [9:0] ca, input logic [31:0] cd,
                       input bit dr, input bit dw, input logic [9:0] da, input logic [31:0] dd);
    cpu_if.req = cr; cpu_if.we = cw; cpu_if.addr = ca; cpu_if.wdata = cd;
    dma_if.req = dr; dma_if.we = dw; dma_if.addr = da; dma_if.wdata = dd;
  endtask

  task automatic tick(input string tag, input bit e_cg, input bit e_dg, input pri_t e_pri, input int e_st);
    logic [31:0] d;
    @(negedge clk);
    chk({tag, " cpu_gnt"}, 32'(cpu_if.gnt), 32'(e_cg));
    chk({tag, " dma_gnt"}, 32'(dma_if.gnt), 32'(e_dg));
    chk({tag, " cpu_stall"}, 32'(cpu_stall), 32'(cpu_if.req & ~e_cg));
    chk({tag, " ram_wren"}, 32'(ram_wren), 32'((e_cg & cpu_if.we) | (e_dg & dma_if.we)));
    if (e_cg || e_dg)
      chk({tag, " ram_address"}, 32'(ram_address), 32'(e_dg ? dma_if.addr : cpu_if.addr));
    chk({tag, " cpu_rvalid"}, 32'(cpu_if.rvalid), 32'(pend == 1));
    chk({tag, " dma_rvalid"}, 32'(dma_if.rvalid), 32'(pend == 2));
    if (pend != 0) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL %s scoreboard: got rvalid expected queued read", tag);
      end else begin
        d = exp_q.pop_front();
        chk({tag, " rdata"}, (pend == 1) ? cpu_if.rdata : dma_if.rdata, d);
      end
    end
    chk({tag, " pri"}, 32'(dbg_pri), 32'(e_pri));
    chk({tag, " starve"}, 32'(dbg_starve), 32'(e_st));
    pend = 0;
    if (e_cg && !cpu_if.we) begin
      exp_q.push_back(rd_mem(cpu_if.addr)); pend = 1;
    end else if (e_dg && !dma_if.we) begin
      exp_q.push_back(rd_mem(dma_if.addr)); pend = 2;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    drive(1, 0, 10'h010, 32'h0, 1, 1, 10'h020, 32'h1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst cpu_gnt", 32'(cpu_if.gnt), 32'h0);
      chk("rst dma_gnt", 32'(dma_if.gnt), 32'h0);
      chk("rst cpu_stall", 32'(cpu_stall), 32'h0);
      chk("rst ram_wren", 32'(ram_wren), 32'h0);
      chk("rst rvalid", 32'({cpu_if.rvalid, dma_if.rvalid}), 32'h0);
      chk("rst pri", 32'(dbg_pri), 32'(PRI_CPU));
      chk("rst starve", 32'(dbg_starve), 32'h0);
      @(posedge clk); #1;
    end
    rst = 1'b1;

    drive(1, 0, 10'h010, 32'h0, 0, 0, 10'h0, 32'h0);
    tick("t1 rd", 1, 0, PRI_CPU, 0);
    drive(0, 0, 10'h0, 32'h0, 0, 0, 10'h0, 32'h0);
    tick("t1 ret", 0, 0, PRI_CPU, 0);

    drive(0, 0, 10'h0, 32'h0, 1, 1, 10'h020, 32'h1234_5678);
    tick("t2 dwr", 0, 1, PRI_CPU, 0);
    chk("t2 written", rd_mem(10'h020), 32'h1234_5678);
    drive(1, 0, 10'h020, 32'h0, 0, 0, 10'h0, 32'h0);
    tick("t2 crd", 1, 0, PRI_CPU, 0);
    drive(0, 0, 10'h0, 32'h0, 0, 0, 10'h0, 32'h0);
    tick("t2 ret", 0, 0, PRI_CPU, 0);

    drive(1, 0, 10'h010, 32'h0, 1, 0, 10'h030, 32'h0);
    alt_on = 1'b1;
    for (int k = 0; k < 10; k++)
      tick("t3", (k % 5) != 4, (k % 5) == 4, ((k % 5) == 4) ? PRI_DMA : PRI_CPU,
           ((k % 5) == 4) ? 0 : (k % 5));
    alt_on = 1'b0;

    for (int k = 0; k < 4; k++) tick("t4 pre", 1, 0, PRI_CPU, k);
    rst = 1'b0;
    @(negedge clk);
    chk("t4 rst cpu_gnt", 32'(cpu_if.gnt), 32'h0);
    chk("t4 rst dma_gnt", 32'(dma_if.gnt), 32'h0);
    chk("t4 rst cpu_stall", 32'(cpu_stall), 32'h0);
    chk("t4 rst ram_wren", 32'(ram_wren), 32'h0);
    chk("t4 rst cpu_rvalid", 32'(cpu_if.rvalid), 32'h0);
    chk("t4 rst pri", 32'(dbg_pri), 32'(PRI_DMA));
    pend = 0;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    tick("t4 post", 1, 0, PRI_CPU, 0);

    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 10'h0, 32'h0, 1, 0, 10'h040 + 10'(i), 32'h0);
      tick("t5", 0, 1, PRI_CPU, (i == 0) ? 1 : 0);
    end
    drive(0, 0, 10'h0, 32'h0, 0, 0, 10'h0, 32'h0);
    tick("t5 ret", 0, 0, PRI_CPU, 0);

    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 10'h050, 32'hC0DE_0000 | 32'(k), 1, 0, 10'h060, 32'h0);
      tick("t6 pre", 1, 0, PRI_CPU, k);
    end
    drive(1, 0, 10'h050, 32'h0, 0, 0, 10'h0, 32'h0);
    tick("t6 slot", 1, 0, PRI_DMA, 0);
    chk("t6 last write", rd_mem(10'h050), 32'hC0DE_0003);
    drive(0, 0, 10'h0, 32'h0, 0, 0, 10'h0, 32'h0);
    tick("t6 after", 0, 0, PRI_CPU, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
